// File: rtl/gpio_in_conditioner.sv
// Conditions raw board inputs for PS GPIO: polarity-normalise, two-FF synchronise,
// debounce per bit, latch sticky edge events and drive a maskable level IRQ.
module gpio_in_conditioner #(
  parameter int N_INPUTS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] pin_in,
  input  logic [N_INPUTS-1:0] ev_clr,
  input  logic [N_INPUTS-1:0] irq_en,
  output logic [N_INPUTS-1:0] level,
  output logic [N_INPUTS-1:0] rise_ev,
  output logic [N_INPUTS-1:0] fall_ev,
  output logic                irq
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0] s0;
  logic [N_INPUTS-1:0] s1;
  logic [N_INPUTS-1:0] s2;
  logic [N_INPUTS-1:0] clr_d;
  logic [N_INPUTS-1:0] clr_pulse;
  logic [N_INPUTS-1:0] at_last;
  logic [N_INPUTS-1:0] set_rise;
  logic [N_INPUTS-1:0] set_fall;

  // Everything downstream of s0 works in logical polarity (1 = active).
  assign s0        = ACTIVE_LOW ? ~pin_in : pin_in;
  assign clr_pulse = ev_clr & ~clr_d;
  assign set_rise  = at_last & s2;
  assign set_fall  = at_last & ~s2;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt;

      // cnt==0 is STABLE, cnt!=0 is PENDING; any agreeing sample discards the run.
      assign at_last[gi] = (s2[gi] != level[gi]) && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (s2[gi] == level[gi] || at_last[gi]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      clr_d   <= '0;
      level   <= '0;
      rise_ev <= '0;
      fall_ev <= '0;
      irq     <= 1'b0;
    end else begin
      s1      <= s0;
      s2      <= s1;
      clr_d   <= ev_clr;
      level   <= level ^ at_last;
      // A new event beats a same-edge clear; the clear still wipes the other flag.
      rise_ev <= set_rise | (rise_ev & ~clr_pulse);
      fall_ev <= set_fall | (fall_ev & ~clr_pulse);
      irq     <= |((rise_ev | fall_ev) & irq_en);
    end
  end
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with DEBOUNCE_CYCLES=8, active-low pins:
// expected values are hand-derived edge counts (10 edges pin-to-level).
module tb_gpio_in_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pin_in;
  logic [1:0] ev_clr;
  logic [1:0] irq_en;
  logic [1:0] level;
  logic [1:0] rise_ev;
  logic [1:0] fall_ev;
  logic       irq;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  gpio_in_conditioner #(
    .N_INPUTS       (2),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pin_in (pin_in),
    .ev_clr (ev_clr),
    .irq_en (irq_en),
    .level  (level),
    .rise_ev(rise_ev),
    .fall_ev(fall_ev),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    pin_in = 2'b11;
    ev_clr = 2'b00;
    irq_en = 2'b00;
    step(3);
    check("rst_level", level, 2'b00);
    check("rst_rise", rise_ev, 2'b00);
    check("rst_fall", fall_ev, 2'b00);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_level", level, 2'b00);
      check("idle_irq", irq, 1'b0);
    end

    // Press bit0: level after exactly 10 edges, irq one edge later.
    irq_en = 2'b01;
    pin_in = 2'b10;
    step(9);
    check("press_level_e9", level, 2'b00);
    step(1);
    check("press_level_e10", level, 2'b01);
    check("press_rise_e10", rise_ev, 2'b01);
    check("press_fall_e10", fall_ev, 2'b00);
    check("press_irq_e10", irq, 1'b0);
    step(1);
    check("press_irq_e11", irq, 1'b1);

    // Bounce on bit1: runs of 5 never reach 8.
    pin_in = 2'b00;
    step(5);
    pin_in = 2'b10;
    step(1);
    pin_in = 2'b00;
    step(5);
    pin_in = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("bounce_level", level, 2'b01);
      check("bounce_rise", rise_ev, 2'b01);
      check("bounce_fall", fall_ev, 2'b00);
    end

    // Clear held high: clears once; a later release still sets fall_ev.
    ev_clr = 2'b01;
    step(1);
    check("clr_rise", rise_ev, 2'b00);
    check("clr_irq_e1", irq, 1'b1);
    step(1);
    check("clr_irq_e2", irq, 1'b0);
    pin_in = 2'b11;
    step(9);
    check("rel_level_e9", level, 2'b01);
    check("rel_fall_e9", fall_ev, 2'b00);
    step(1);
    check("rel_level_e10", level, 2'b00);
    check("rel_fall_e10", fall_ev, 2'b01);
    check("rel_rise_e10", rise_ev, 2'b00);
    check("rel_irq_e10", irq, 1'b0);
    step(1);
    check("rel_irq_e11", irq, 1'b1);
    ev_clr = 2'b00;
    step(1);

    // Clear edge coincides with fall event: set wins, rise flag cleared.
    pin_in = 2'b10;
    step(10);
    check("coin_press_level", level, 2'b01);
    check("coin_press_rise", rise_ev, 2'b01);
    check("coin_press_fall", fall_ev, 2'b01);
    pin_in = 2'b11;
    step(9);
    check("coin_level_e9", level, 2'b01);
    ev_clr = 2'b01;
    step(1);
    check("coin_level_e10", level, 2'b00);
    check("coin_fall", fall_ev, 2'b01);
    check("coin_rise", rise_ev, 2'b00);
    check("coin_irq_e10", irq, 1'b1);
    step(1);
    check("coin_irq_e11", irq, 1'b1);
    ev_clr = 2'b00;

    // Reset at cnt=5 with the pin held active through reset.
    pin_in = 2'b10;
    step(7);
    check("mid_level", level, 2'b00);
    rst = 1'b1;
    step(1);
    check("mid_rst_level", level, 2'b00);
    check("mid_rst_rise", rise_ev, 2'b00);
    check("mid_rst_fall", fall_ev, 2'b00);
    check("mid_rst_irq", irq, 1'b0);
    rst = 1'b0;
    step(9);
    check("post_rst_level_e9", level, 2'b00);
    check("post_rst_rise_e9", rise_ev, 2'b00);
    step(1);
    check("post_rst_level_e10", level, 2'b01);
    check("post_rst_rise_e10", rise_ev, 2'b01);
    check("post_rst_fall_e10", fall_ev, 2'b00);
    step(1);
    check("post_rst_irq", irq, 1'b1);

    // Mask: irq drops one edge after irq_en falls; bit1 event stays masked until enabled.
    irq_en = 2'b00;
    step(1);
    check("mask_irq", irq, 1'b0);
    pin_in = 2'b00;
    step(10);
    check("b1_level", level, 2'b11);
    check("b1_rise", rise_ev, 2'b11);
    check("b1_irq_masked", irq, 1'b0);
    step(1);
    check("b1_irq_masked2", irq, 1'b0);
    irq_en = 2'b10;
    step(1);
    check("b1_irq_en", irq, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
